// File: rtl/regfile_write_scheduler_if.sv
// Write-port bundle between the two writeback requesters, the clear control,
// and the register file write inputs driven by the scheduler.
interface regfile_write_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                  req0Valid;
  logic [ADDR_WIDTH-1:0] req0Address;
  logic [DATA_WIDTH-1:0] req0Data;
  logic                  req0Ready;
  logic                  req1Valid;
  logic [ADDR_WIDTH-1:0] req1Address;
  logic [DATA_WIDTH-1:0] req1Data;
  logic                  req1Ready;
  logic                  clearStart;
  logic                  clearBusy;
  logic                  write;
  logic [ADDR_WIDTH-1:0] inAddress;
  logic [DATA_WIDTH-1:0] dataIn;

  modport master (
    output req0Valid, req0Address, req0Data, req1Valid, req1Address, req1Data, clearStart,
    input  req0Ready, req1Ready, clearBusy, write, inAddress, dataIn
  );

  modport slave (
    input  req0Valid, req0Address, req0Data, req1Valid, req1Address, req1Data, clearStart,
    output req0Ready, req1Ready, clearBusy, write, inAddress, dataIn
  );
endinterface

// File: rtl/regfile_write_scheduler.sv
// Round-robin scheduler for the register file write port with a built-in
// sequence that zeroes every register; write-port outputs are registered.
module regfile_write_scheduler #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  regfile_write_scheduler_if.slave  bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;
  logic [ADDR_WIDTH-1:0] clr_idx_q, clr_idx_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  busy_q, busy_d;
  logic                  ready0_c, ready1_c;

  // State and registered write-port outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      clr_idx_q <= '0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      clr_idx_q <= clr_idx_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
    end
  end

  // Arbitration, clear sequencing and next-cycle write-port values
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    clr_idx_d = clr_idx_q;
    write_d   = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    busy_d    = 1'b0;
    ready0_c  = 1'b0;
    ready1_c  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.clearStart) begin
          state_d   = CLEAR;
          clr_idx_d = '0;
          busy_d    = 1'b1;
        end else begin
          // prio only matters when both requesters contend
          if (bus.req0Valid && (!bus.req1Valid || !prio_q)) begin
            ready0_c = 1'b1;
          end else if (bus.req1Valid) begin
            ready1_c = 1'b1;
          end

          if (ready0_c) begin
            write_d = 1'b1;
            addr_d  = bus.req0Address;
            data_d  = bus.req0Data;
            prio_d  = 1'b1;
          end else if (ready1_c) begin
            write_d = 1'b1;
            addr_d  = bus.req1Address;
            data_d  = bus.req1Data;
            prio_d  = 1'b0;
          end
        end
      end

      CLEAR: begin
        write_d = 1'b1;
        addr_d  = clr_idx_q;
        data_d  = '0;
        // busy drops on the same edge that issues the final zero-write
        if (clr_idx_q == LAST_IDX) begin
          state_d   = IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
          busy_d    = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Readies are forced low for as long as reset is held
  assign bus.req0Ready = ready0_c & reset;
  assign bus.req1Ready = ready1_c & reset;
  assign bus.clearBusy = busy_q;
  assign bus.write     = write_q;
  assign bus.inAddress = addr_q;
  assign bus.dataIn    = data_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Directed bench for regfile_write_scheduler with a behavioural register file
// that commits on the edge after the scheduler registers a write.
module tb_regfile_write_scheduler;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [7:0] rf [8];

  regfile_write_scheduler_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  regfile_write_scheduler #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .NUM_REGS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model
  always @(posedge clk) begin
    if (bus.write === 1'b1) rf[bus.inAddress] <= bus.dataIn;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic chk_out(input string tag, input logic w, input logic [2:0] a, input logic [7:0] d);
    chk({tag, "_write"}, 8'(bus.write), 8'(w));
    chk({tag, "_addr"},  8'(bus.inAddress), 8'(a));
    chk({tag, "_data"},  bus.dataIn, d);
  endtask

  task automatic chk_rdy(input string tag, input logic r0, input logic r1);
    #1;
    chk({tag, "_rdy0"}, 8'(bus.req0Ready), 8'(r0));
    chk({tag, "_rdy1"}, 8'(bus.req1Ready), 8'(r1));
  endtask

  task automatic preload(input logic [7:0] base);
    bus.req0Valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.req0Address = 3'(i);
      bus.req0Data    = base + 8'(i);
      step();
    end
    bus.req0Valid = 1'b0;
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    bus.req0Valid = 1'b0; bus.req0Address = '0; bus.req0Data = '0;
    bus.req1Valid = 1'b0; bus.req1Address = '0; bus.req1Data = '0;
    bus.clearStart = 1'b0;

    // Reset state, readies held low even with valids up
    step();
    step();
    chk_out("rst", 1'b0, 3'd0, 8'd0);
    chk("rst_busy", 8'(bus.clearBusy), 8'd0);
    bus.req0Valid = 1'b1;
    bus.req1Valid = 1'b1;
    chk_rdy("rst", 1'b0, 1'b0);
    bus.req0Valid = 1'b0;
    bus.req1Valid = 1'b0;
    reset = 1'b1;

    // Single write from requester 0
    bus.req0Valid = 1'b1; bus.req0Address = 3'd2; bus.req0Data = 8'd24;
    chk_rdy("single", 1'b1, 1'b0);
    step();
    bus.req0Valid = 1'b0;
    chk_out("single", 1'b1, 3'd2, 8'd24);
    step();
    chk_out("single_hold", 1'b0, 3'd2, 8'd24);
    chk("single_rf2", rf[2], 8'd24);

    // Contention from reset alternates grants
    apply_reset();
    bus.req0Valid = 1'b1; bus.req0Address = 3'd1; bus.req0Data = 8'd5;
    bus.req1Valid = 1'b1; bus.req1Address = 3'd4; bus.req1Data = 8'd12;
    for (int i = 0; i < 4; i++) begin
      chk_rdy("rr", (i % 2) == 0, (i % 2) == 1);
      step();
      if ((i % 2) == 0) chk_out("rr", 1'b1, 3'd1, 8'd5);
      else              chk_out("rr", 1'b1, 3'd4, 8'd12);
    end
    bus.req0Valid = 1'b0;
    bus.req1Valid = 1'b0;
    step();
    chk("rr_rf1", rf[1], 8'd5);
    chk("rr_rf4", rf[4], 8'd12);

    // Same address: grant order decides the final value
    bus.req0Valid = 1'b1; bus.req0Address = 3'd3; bus.req0Data = 8'd7;
    bus.req1Valid = 1'b1; bus.req1Address = 3'd3; bus.req1Data = 8'd9;
    chk_rdy("same", 1'b1, 1'b0);
    step();
    bus.req0Valid = 1'b0;
    chk_out("same0", 1'b1, 3'd3, 8'd7);
    chk_rdy("same", 1'b0, 1'b1);
    step();
    bus.req1Valid = 1'b0;
    chk_out("same1", 1'b1, 3'd3, 8'd9);
    step();
    chk("same_rf3", rf[3], 8'd9);

    // Clear with both requesters pending
    preload(8'h10);
    chk("pre_rf7", rf[7], 8'h17);
    bus.req0Valid = 1'b1; bus.req0Address = 3'd5; bus.req0Data = 8'hAA;
    bus.req1Valid = 1'b1; bus.req1Address = 3'd6; bus.req1Data = 8'hBB;
    bus.clearStart = 1'b1;
    chk_rdy("clr_start", 1'b0, 1'b0);
    step();
    bus.clearStart = 1'b0;
    chk("clr_dead_busy", 8'(bus.clearBusy), 8'd1);
    chk("clr_dead_write", 8'(bus.write), 8'd0);
    for (int j = 0; j < 8; j++) begin
      bus.clearStart = (j == 2 || j == 3);
      chk_rdy("clr", 1'b0, 1'b0);
      step();
      chk_out("clr", 1'b1, 3'(j), 8'd0);
      chk("clr_busy", 8'(bus.clearBusy), 8'((j < 7) ? 1 : 0));
    end
    bus.clearStart = 1'b0;
    chk_rdy("clr_resume", 1'b0, 1'b1);
    step();
    bus.req1Valid = 1'b0;
    chk_out("clr_resume1", 1'b1, 3'd6, 8'hBB);
    chk_rdy("clr_resume", 1'b1, 1'b0);
    step();
    bus.req0Valid = 1'b0;
    chk_out("clr_resume0", 1'b1, 3'd5, 8'hAA);
    step();
    for (int i = 0; i < 8; i++) begin
      if (i == 5)      chk("clr_rf5", rf[i], 8'hAA);
      else if (i == 6) chk("clr_rf6", rf[i], 8'hBB);
      else             chk("clr_rf_zero", rf[i], 8'h00);
    end

    // Clear start beats a simultaneous request
    bus.req1Valid = 1'b1; bus.req1Address = 3'd2; bus.req1Data = 8'h55;
    bus.clearStart = 1'b1;
    chk_rdy("cs_race", 1'b0, 1'b0);
    step();
    bus.clearStart = 1'b0;
    chk("cs_busy", 8'(bus.clearBusy), 8'd1);
    for (int j = 0; j < 8; j++) begin
      chk_rdy("cs_wait", 1'b0, 1'b0);
      step();
    end
    chk("cs_busy_fall", 8'(bus.clearBusy), 8'd0);
    chk_rdy("cs_after", 1'b0, 1'b1);
    step();
    bus.req1Valid = 1'b0;
    chk_out("cs_grant", 1'b1, 3'd2, 8'h55);
    step();
    chk("cs_rf2", rf[2], 8'h55);

    // Reset in the middle of a clear
    preload(8'h20);
    bus.clearStart = 1'b1;
    step();
    bus.clearStart = 1'b0;
    step();
    step();
    step();
    chk_out("mid_r2", 1'b1, 3'd2, 8'd0);
    step();
    bus.req0Valid = 1'b1; bus.req0Address = 3'd7; bus.req0Data = 8'h77;
    bus.req1Valid = 1'b1; bus.req1Address = 3'd6; bus.req1Data = 8'h66;
    reset = 1'b0;
    #1;
    chk_out("mid_rst", 1'b0, 3'd0, 8'd0);
    chk("mid_rst_busy", 8'(bus.clearBusy), 8'd0);
    chk_rdy("mid_rst", 1'b0, 1'b0);
    step();
    step();
    for (int i = 0; i < 8; i++) begin
      if (i < 3) chk("mid_rf_cleared", rf[i], 8'h00);
      else       chk("mid_rf_kept", rf[i], 8'h20 + 8'(i));
    end
    reset = 1'b1;
    chk_rdy("mid_prio", 1'b1, 1'b0);
    bus.req0Valid = 1'b0;
    bus.req1Valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
